prog_rom_arbiter: RTL and testbench
===================================

PROG_ROM_ARBITER -- requirements
Module: prog_rom_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, meaning the program ROM word-address width.
REQ-002 SHALL have parameter RST_CYCLES, default 2, meaning the CPU-reset pulse length after a load.
REQ-003 SHALL have port clock, input, 1, posedge system clock.
REQ-004 SHALL have port reset, input, 1, reset (synchronous, active-high).
REQ-005 SHALL have port mode_sw, input, 1, level request for upload mode.
REQ-006 SHALL have port rx_valid, input, 1, one-cycle strobe for a received UART byte.
REQ-007 SHALL have port rx_byte, input, 8, the received UART byte.
REQ-008 SHALL have port cpu_rom_addr, input, ADDR_W, the fetch word address from the CPU.
REQ-009 SHALL have port rom_addr, output, ADDR_W, the ROM port address.
REQ-010 SHALL have port rom_wdata, output, 32, the ROM write data.
REQ-011 SHALL have port rom_we, output, 1, the ROM write enable.
REQ-012 SHALL have port cpu_stall, output, 1, which holds the CPU PC and inhibits CPU fetch use.
REQ-013 SHALL have port cpu_rst_o, output, 1, the CPU reset request.
REQ-014 SHALL have port words_loaded, output, ADDR_W+1, the count of words written in the current or last load.
REQ-015 SHALL have port ovf, output, 1, a sticky flag set when ROM-full writes are dropped.

Function
REQ-016 SHALL implement FSM states RUN, LOAD, FLUSH, RESTART.
REQ-017 RUN: rom_addr SHALL equal cpu_rom_addr combinationally, with rom_we=0, cpu_stall=0 and cpu_rst_o=0.
REQ-018 RUN with mode_sw=1 SHALL go to LOAD next cycle, clearing wr_ptr, byte_cnt, words_loaded and ovf on entry.
REQ-019 In LOAD, FLUSH and RESTART, cpu_stall SHALL be 1 and rom_addr SHALL be wr_ptr.
REQ-020 LOAD: each rx_valid SHALL place rx_byte into lane byte_cnt (first byte into [7:0], little-endian) and increment byte_cnt mod 4.
REQ-021 When the 4th byte is accepted, rom_we SHALL pulse for exactly one cycle the following cycle, with rom_wdata holding the full word and rom_addr=wr_ptr.
REQ-022 After each write, wr_ptr and words_loaded SHALL increment in the same cycle as the rom_we pulse.
REQ-023 Bytes arriving during the rom_we cycle SHALL be accepted into the next word, with no drop.
REQ-024 Full condition: once wr_ptr has written address 2^ADDR_W-1, later completed words SHALL NOT assert rom_we, wr_ptr SHALL NOT wrap, and ovf SHALL set and remain set until the next LOAD entry.
REQ-025 LOAD with mode_sw=0 and byte_cnt=0 (and no pending write) SHALL go to RESTART.
REQ-026 LOAD with mode_sw=0 and byte_cnt≠0 SHALL go to FLUSH.
REQ-027 FLUSH SHALL zero-fill the unfilled lanes, issue one rom_we pulse, increment counts (subject to REQ-024), then go to RESTART.
REQ-028 If mode_sw falls in the same cycle the 4th byte is accepted, that word SHALL be written and the FSM SHALL go to RESTART, not FLUSH.
REQ-029 rx_valid in FLUSH, RESTART or RUN SHALL be ignored.
REQ-030 RESTART SHALL assert cpu_rst_o for exactly RST_CYCLES cycles, then return to RUN.
REQ-031 mode_sw=1 during RESTART SHALL be ignored until RUN is reached.
REQ-032 words_loaded SHALL hold its value through RUN until the next LOAD entry.

Reset
REQ-033 Reset SHALL force the FSM to RUN and clear wr_ptr, byte_cnt, rom_wdata, rom_we, words_loaded and ovf.
REQ-034 During reset, cpu_stall and cpu_rst_o SHALL be 0.
REQ-035 Reset mid-LOAD SHALL abandon any partial word without writing it.
REQ-036 Reset SHALL take priority over all other inputs.

Structure
REQ-037 The FSM state encoding, RST_CYCLES default and the byte-lane count (4) SHALL live in the shared CPU package.
REQ-038 The byte-to-word assembly (lane register, byte_cnt, zero-fill) SHALL be one sub-module named byte_packer.
REQ-039 The FSM, wr_ptr and the ROM port mux SHALL remain in prog_rom_arbiter.

Verification
REQ-040 Run passthrough: cpu_rom_addr=0x0123 in RUN -> rom_addr=0x0123 same cycle, with rom_we=0 and cpu_stall=0.
REQ-041 Load 8 bytes 0x11..0x88, then drop mode_sw -> writes 0x44332211@0 and 0x88776655@1, words_loaded=2, then cpu_rst_o high for 2 cycles, then RUN.
REQ-042 Partial word: bytes 0xAA,0xBB, then drop mode_sw -> FLUSH writes 0x0000BBAA@0, words_loaded=1.
REQ-043 Simultaneous event: 4th byte and mode_sw fall in the same cycle -> exactly one write, no FLUSH, then RESTART.
REQ-044 Full: ADDR_W=2, load 5 words -> 4 writes at 0..3, 5th dropped, ovf=1, wr_ptr does not wrap.
REQ-045 Reset mid-LOAD after 3 bytes -> no rom_we, state RUN, all counters 0.

Source files
------------

// File: rtl/prog_rom_arbiter_pkg.sv
// Shared CPU package: ROM-loader FSM encoding, reset-pulse default and byte-lane geometry.
package prog_rom_arbiter_pkg;

  localparam int unsigned NUM_LANES      = 4;
  localparam int unsigned LANE_W         = 8;
  localparam int unsigned LANE_IDX_W     = $clog2(NUM_LANES);
  localparam int unsigned WORD_W         = NUM_LANES * LANE_W;
  localparam int unsigned RST_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LOAD    = 2'd1,
    FLUSH   = 2'd2,
    RESTART = 2'd3
  } arb_state_e;

  typedef logic [NUM_LANES-1:0][LANE_W-1:0] word_lanes_t;

endpackage

// File: rtl/prog_rom_arbiter_byte_packer.sv
// Assembles little-endian 32-bit words from a UART byte stream; flush zero-fills unfilled lanes.
module byte_packer
  import prog_rom_arbiter_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  accept,
  input  logic                  flush,
  input  logic [LANE_W-1:0]     rx_byte,
  output logic [WORD_W-1:0]     word_c,
  output logic                  word_done_c,
  output logic [LANE_IDX_W-1:0] cnt_next_c
);

  word_lanes_t           lanes_q, lanes_d;
  word_lanes_t           merged, filled;
  logic [LANE_IDX_W-1:0] byte_cnt_q, byte_cnt_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      lanes_q    <= '0;
      byte_cnt_q <= '0;
    end else begin
      lanes_q    <= lanes_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  // word_c already includes the byte accepted this cycle so a completed word can be registered directly
  always_comb begin
    merged = lanes_q;
    if (accept) merged[byte_cnt_q] = rx_byte;

    filled = lanes_q;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (LANE_IDX_W'(i) >= byte_cnt_q) filled[i] = '0;
    end

    word_done_c = accept && (byte_cnt_q == LANE_IDX_W'(NUM_LANES - 1));
    word_c      = flush ? WORD_W'(filled) : WORD_W'(merged);

    lanes_d    = lanes_q;
    byte_cnt_d = byte_cnt_q;
    if (clear || flush || word_done_c) begin
      lanes_d    = '0;
      byte_cnt_d = '0;
    end else if (accept) begin
      lanes_d    = merged;
      byte_cnt_d = byte_cnt_q + LANE_IDX_W'(1);
    end
    cnt_next_c = byte_cnt_d;
  end

endmodule

// File: rtl/prog_rom_arbiter.sv
// Shares the program ROM port between CPU fetch and a UART upload path, then pulses CPU reset.
module prog_rom_arbiter
  import prog_rom_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned RST_CYCLES = RST_CYCLES_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mode_sw,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  input  logic [ADDR_W-1:0] cpu_rom_addr,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [31:0]       rom_wdata,
  output logic              rom_we,
  output logic              cpu_stall,
  output logic              cpu_rst_o,
  output logic [ADDR_W:0]   words_loaded,
  output logic              ovf
);

  localparam int unsigned CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  arb_state_e            state_q, state_d;
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic                  full_q, full_d;
  logic [ADDR_W:0]       words_q, words_d;
  logic                  ovf_q, ovf_d;
  logic                  rom_we_q, rom_we_d;
  logic [WORD_W-1:0]     rom_wdata_q, rom_wdata_d;
  logic [CNT_W-1:0]      rst_cnt_q, rst_cnt_d;
  logic                  cpu_stall_q, cpu_rst_q;

  logic                  pk_clear, pk_accept, pk_flush;
  logic [WORD_W-1:0]     pk_word;
  logic                  pk_done;
  logic [LANE_IDX_W-1:0] pk_cnt_next;
  logic                  write_blocked;

  byte_packer u_byte_packer (
    .clock       (clock),
    .reset       (reset),
    .clear       (pk_clear),
    .accept      (pk_accept),
    .flush       (pk_flush),
    .rx_byte     (rx_byte),
    .word_c      (pk_word),
    .word_done_c (pk_done),
    .cnt_next_c  (pk_cnt_next)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= RUN;
      wr_ptr_q    <= '0;
      full_q      <= 1'b0;
      words_q     <= '0;
      ovf_q       <= 1'b0;
      rom_we_q    <= 1'b0;
      rom_wdata_q <= '0;
      rst_cnt_q   <= '0;
      cpu_stall_q <= 1'b0;
      cpu_rst_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      full_q      <= full_d;
      words_q     <= words_d;
      ovf_q       <= ovf_d;
      rom_we_q    <= rom_we_d;
      rom_wdata_q <= rom_wdata_d;
      rst_cnt_q   <= rst_cnt_d;
      cpu_stall_q <= (state_d != RUN);
      cpu_rst_q   <= (state_d == RESTART);
    end
  end

  // Top address is either already written or being written this cycle
  assign write_blocked = full_q || (rom_we_q && (wr_ptr_q == ADDR_MAX));

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    full_d      = full_q;
    words_d     = words_q;
    ovf_d       = ovf_q;
    rom_we_d    = 1'b0;
    rom_wdata_d = rom_wdata_q;
    rst_cnt_d   = rst_cnt_q;
    pk_clear    = 1'b0;
    pk_accept   = 1'b0;
    pk_flush    = 1'b0;

    // Retire the write presented this cycle; the pointer saturates at the top address
    if (rom_we_q) begin
      words_d = words_q + (ADDR_W + 1)'(1);
      if (wr_ptr_q == ADDR_MAX) full_d = 1'b1;
      else                      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end

    unique case (state_q)
      RUN: begin
        if (mode_sw) begin
          state_d  = LOAD;
          pk_clear = 1'b1;
          wr_ptr_d = '0;
          full_d   = 1'b0;
          words_d  = '0;
          ovf_d    = 1'b0;
        end
      end
      LOAD: begin
        pk_accept = rx_valid;
        if (pk_done) begin
          if (write_blocked) ovf_d = 1'b1;
          else begin
            rom_we_d    = 1'b1;
            rom_wdata_d = pk_word;
          end
        end
        if (!mode_sw) state_d = (pk_cnt_next != '0) ? FLUSH : RESTART;
      end
      FLUSH: begin
        pk_flush = 1'b1;
        if (write_blocked) ovf_d = 1'b1;
        else begin
          rom_we_d    = 1'b1;
          rom_wdata_d = pk_word;
        end
        state_d = RESTART;
      end
      RESTART: begin
        if (rst_cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = RUN;
        else                                     rst_cnt_d = rst_cnt_q + CNT_W'(1);
      end
    endcase

    if ((state_d == RESTART) && (state_q != RESTART)) rst_cnt_d = '0;
  end

  assign rom_addr     = (state_q == RUN) ? cpu_rom_addr : wr_ptr_q;
  assign rom_wdata    = rom_wdata_q;
  assign rom_we       = rom_we_q;
  assign cpu_stall    = cpu_stall_q;
  assign cpu_rst_o    = cpu_rst_q;
  assign words_loaded = words_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_prog_rom_arbiter.sv
// Directed bench: a default-width instance and a 2-bit-address instance share one stimulus stream.
module tb_prog_rom_arbiter;

  logic        clock = 1'b0;
  logic        reset, mode_sw, rx_valid;
  logic [7:0]  rx_byte;
  logic [13:0] cpu_rom_addr;

  logic [13:0] rom_addr_a;
  logic [31:0] rom_wdata_a;
  logic        rom_we_a, cpu_stall_a, cpu_rst_o_a, ovf_a;
  logic [14:0] words_loaded_a;

  logic [1:0]  rom_addr_b;
  logic [31:0] rom_wdata_b;
  logic        rom_we_b, cpu_stall_b, cpu_rst_o_b, ovf_b;
  logic [2:0]  words_loaded_b;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  prog_rom_arbiter u_dut_a (
    .clock(clock), .reset(reset), .mode_sw(mode_sw), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .cpu_rom_addr(cpu_rom_addr), .rom_addr(rom_addr_a), .rom_wdata(rom_wdata_a), .rom_we(rom_we_a),
    .cpu_stall(cpu_stall_a), .cpu_rst_o(cpu_rst_o_a), .words_loaded(words_loaded_a), .ovf(ovf_a)
  );

  prog_rom_arbiter #(.ADDR_W(2), .RST_CYCLES(2)) u_dut_b (
    .clock(clock), .reset(reset), .mode_sw(mode_sw), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .cpu_rom_addr(cpu_rom_addr[1:0]), .rom_addr(rom_addr_b), .rom_wdata(rom_wdata_b), .rom_we(rom_we_b),
    .cpu_stall(cpu_stall_b), .cpu_rst_o(cpu_rst_o_b), .words_loaded(words_loaded_b), .ovf(ovf_b)
  );

  // ROM write loggers
  int          wa_n = 0;
  logic [31:0] wa_data [64];
  logic [13:0] wa_addr [64];
  int          wb_n = 0;
  logic [31:0] wb_data [64];
  logic [1:0]  wb_addr [64];

  always @(negedge clock) begin
    if (rom_we_a) begin
      if (wa_n < 64) begin
        wa_data[wa_n] <= rom_wdata_a;
        wa_addr[wa_n] <= rom_addr_a;
      end
      wa_n <= wa_n + 1;
    end
    if (rom_we_b) begin
      if (wb_n < 64) begin
        wb_data[wb_n] <= rom_wdata_b;
        wb_addr[wb_n] <= rom_addr_b;
      end
      wb_n <= wb_n + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    int base_a, base_b, rc;
    reset = 1'b1; mode_sw = 1'b0; rx_valid = 1'b0; rx_byte = '0; cpu_rom_addr = '0;

    // reset state
    repeat (3) tick();
    @(negedge clock);
    check_eq("rst_stall",  32'(cpu_stall_a), 32'd0);
    check_eq("rst_cpurst", 32'(cpu_rst_o_a), 32'd0);
    check_eq("rst_we",     32'(rom_we_a), 32'd0);
    check_eq("rst_words",  32'(words_loaded_a), 32'd0);
    check_eq("rst_ovf",    32'(ovf_a), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // RUN passthrough
    cpu_rom_addr = 14'h0123;
    #1;
    check_eq("pass_addr",  32'(rom_addr_a), 32'h0123);
    check_eq("pass_we",    32'(rom_we_a), 32'd0);
    check_eq("pass_stall", 32'(cpu_stall_a), 32'd0);

    // two full words then restart
    base_a = wa_n;
    mode_sw = 1'b1;
    tick();
    @(negedge clock);
    check_eq("load_stall", 32'(cpu_stall_a), 32'd1);
    for (int i = 0; i < 8; i++) send(8'(8'h11 * (i + 1)));
    repeat (2) tick();
    mode_sw = 1'b0;
    rc = 0;
    repeat (8) begin
      @(negedge clock);
      if (cpu_rst_o_a) rc++;
    end
    check_eq("w2_rst_cycles", 32'(rc), 32'd2);
    check_eq("w2_stall_run",  32'(cpu_stall_a), 32'd0);
    check_eq("w2_nwr",   32'(wa_n - base_a), 32'd2);
    check_eq("w2_addr0", 32'(wa_addr[base_a]), 32'd0);
    check_eq("w2_data0", wa_data[base_a], 32'h44332211);
    check_eq("w2_addr1", 32'(wa_addr[base_a+1]), 32'd1);
    check_eq("w2_data1", wa_data[base_a+1], 32'h88776655);
    check_eq("w2_words", 32'(words_loaded_a), 32'd2);
    check_eq("w2_run_addr", 32'(rom_addr_a), 32'h0123);

    // bytes in RUN are ignored and words_loaded holds
    tick();
    for (int i = 0; i < 4; i++) send(8'hE0 + 8'(i));
    repeat (3) tick();
    @(negedge clock);
    check_eq("run_rx_nwr",  32'(wa_n - base_a), 32'd2);
    check_eq("run_words",   32'(words_loaded_a), 32'd2);

    // partial word flushed with zero fill
    tick();
    base_a = wa_n;
    mode_sw = 1'b1;
    tick();
    send(8'hAA);
    send(8'hBB);
    mode_sw = 1'b0;
    repeat (6) tick();
    @(negedge clock);
    check_eq("fl_nwr",   32'(wa_n - base_a), 32'd1);
    check_eq("fl_addr",  32'(wa_addr[base_a]), 32'd0);
    check_eq("fl_data",  wa_data[base_a], 32'h0000BBAA);
    check_eq("fl_words", 32'(words_loaded_a), 32'd1);

    // 4th byte and mode_sw fall together; mode_sw re-raised during RESTART
    tick();
    base_a = wa_n;
    mode_sw = 1'b1;
    tick();
    send(8'h01);
    send(8'h02);
    send(8'h03);
    rx_valid = 1'b1; rx_byte = 8'h04; mode_sw = 1'b0;
    tick();
    rx_valid = 1'b0;
    @(negedge clock);
    check_eq("sim_we",     32'(rom_we_a), 32'd1);
    check_eq("sim_cpurst", 32'(cpu_rst_o_a), 32'd1);
    mode_sw = 1'b1;
    @(negedge clock);
    check_eq("rs_hold_rst", 32'(cpu_rst_o_a), 32'd1);
    @(negedge clock);
    check_eq("rs_run_stall", 32'(cpu_stall_a), 32'd0);
    check_eq("rs_run_rst",   32'(cpu_rst_o_a), 32'd0);
    @(negedge clock);
    check_eq("rs_reload", 32'(cpu_stall_a), 32'd1);
    check_eq("sim_nwr",   32'(wa_n - base_a), 32'd1);
    check_eq("sim_data",  wa_data[base_a], 32'h04030201);
    mode_sw = 1'b0;
    repeat (6) tick();
    @(negedge clock);
    check_eq("empty_words", 32'(words_loaded_a), 32'd0);
    check_eq("empty_stall", 32'(cpu_stall_a), 32'd0);

    // ROM full on the 2-bit instance
    tick();
    base_a = wa_n;
    base_b = wb_n;
    mode_sw = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) send(8'(i + 1));
    repeat (2) tick();
    @(negedge clock);
    check_eq("full_ptr",   32'(rom_addr_b), 32'd3);
    check_eq("full_ovf",   32'(ovf_b), 32'd1);
    check_eq("full_words", 32'(words_loaded_b), 32'd4);
    check_eq("wide_ovf",   32'(ovf_a), 32'd0);
    check_eq("wide_words", 32'(words_loaded_a), 32'd5);
    mode_sw = 1'b0;
    repeat (6) tick();
    @(negedge clock);
    check_eq("full_nwr", 32'(wb_n - base_b), 32'd4);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] exp;
      exp = {8'(4*k + 4), 8'(4*k + 3), 8'(4*k + 2), 8'(4*k + 1)};
      check_eq($sformatf("full_addr%0d", k), 32'(wb_addr[base_b+k]), 32'(k));
      check_eq($sformatf("full_data%0d", k), wb_data[base_b+k], exp);
    end
    check_eq("full_ovf_sticky", 32'(ovf_b), 32'd1);
    check_eq("wide_nwr", 32'(wa_n - base_a), 32'd5);

    // reset mid-LOAD after 3 bytes, with competing inputs held
    tick();
    base_a = wa_n;
    mode_sw = 1'b1;
    tick();
    send(8'h31);
    send(8'h32);
    send(8'h33);
    reset = 1'b1; rx_valid = 1'b1; rx_byte = 8'h34;
    tick();
    @(negedge clock);
    check_eq("mr_we",    32'(rom_we_a), 32'd0);
    check_eq("mr_stall", 32'(cpu_stall_a), 32'd0);
    check_eq("mr_rst",   32'(cpu_rst_o_a), 32'd0);
    check_eq("mr_ovf_b", 32'(ovf_b), 32'd0);
    check_eq("mr_words", 32'(words_loaded_a), 32'd0);
    tick();
    reset = 1'b0; rx_valid = 1'b0; mode_sw = 1'b0;
    repeat (4) tick();
    @(negedge clock);
    check_eq("mr_nwr",   32'(wa_n - base_a), 32'd0);
    check_eq("mr_run",   32'(rom_addr_a), 32'h0123);

    // fresh load after reset starts at lane 0, address 0
    tick();
    mode_sw = 1'b1;
    tick();
    send(8'hDE);
    send(8'hAD);
    send(8'hBE);
    send(8'hEF);
    tick();
    mode_sw = 1'b0;
    repeat (6) tick();
    @(negedge clock);
    check_eq("pr_nwr",   32'(wa_n - base_a), 32'd1);
    check_eq("pr_addr",  32'(wa_addr[base_a]), 32'd0);
    check_eq("pr_data",  wa_data[base_a], 32'hEFBEADDE);
    check_eq("pr_words", 32'(words_loaded_a), 32'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
